uart_word_assembler: RTL and testbench
======================================

# uart_word_assembler

Packs a stream of UART receiver bytes into parametrised-width words for the debug unit. Supports a configurable byte count per word, a byte-order mode, an inter-byte timeout that discards stale partial words, and a one-entry valid/ready output register with overflow reporting. It sits between the UART receiver's `rx_done`/data outputs and the debug unit command decoder.

## Interface
Parameters:
- `BYTE_WIDTH`, default 8: width of one received byte.
- `BYTES_PER_WORD`, default 4: bytes per assembled word. Legal values are 2 or more.
- `TIMEOUT_CYCLES`, default 0: number of idle `i_clk` cycles allowed between bytes of a partial word. 0 disables the timeout.

Ports (reset `i_reset`, synchronous, active-high; clock `i_clk`):
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  synchronous active-high reset.
- `i_byte_valid`  in  1  one-cycle strobe from the receiver's `rx_done`.
- `i_byte`  in  `BYTE_WIDTH`  received byte, qualified by `i_byte_valid`.
- `i_msb_first`  in  1  byte order. 0: the first byte lands in the LSBs. 1: the first byte lands in the MSBs.
- `i_word_ready`  in  1  consumer accepts `o_word` when this and `o_word_valid` are both high.
- `o_word`  out  `BYTE_WIDTH*BYTES_PER_WORD`  assembled word.
- `o_word_valid`  out  1  `o_word` holds an unconsumed word.
- `o_byte_count`  out  `$clog2(BYTES_PER_WORD+1)`  bytes in the current partial word.
- `o_overflow`  out  1  one-cycle pulse when a completed word is dropped.
- `o_timeout`  out  1  one-cycle pulse when a partial word is discarded.

## Operation
- Internal state:
  - assembly register `asm`, with `BYTES_PER_WORD*BYTE_WIDTH` bits;
  - byte counter `cnt`;
  - latched order bit `ord`;
  - idle counter `idle`;
  - output register `o_word` with its `o_word_valid` flag.
- States:
  - COLLECT_EMPTY: `cnt`=0.
  - COLLECT_PARTIAL: 0<`cnt`<N.
- A byte arriving in COLLECT_EMPTY does three things: latches `i_msb_first` into `ord`, sets `cnt` to 1 and moves to COLLECT_PARTIAL. Changes to `i_msb_first` mid-word are ignored.
- Byte placement for the k-th byte of a word, k = 0..N-1:
  - `ord`=0: bits `[k*BYTE_WIDTH +: BYTE_WIDTH]`.
  - `ord`=1: bits `[(N-1-k)*BYTE_WIDTH +: BYTE_WIDTH]`.
- Word completion. On the N-th byte:
  - the completed word (`asm` with the final byte merged) transfers to `o_word`;
  - `cnt` returns to 0 and the state returns to COLLECT_EMPTY;
  - the transfer happens only if the output slot is free, meaning `o_word_valid`=0 or acceptance happens this cycle.
- Overflow. The N-th byte arrives while `o_word_valid`=1 and `i_word_ready`=0:
  - the completed word is dropped;
  - `o_word` and `o_word_valid` are unchanged;
  - `o_overflow` pulses for 1 cycle;
  - `cnt` returns to 0.
- Acceptance (`o_word_valid`&`i_word_ready`) clears `o_word_valid` next cycle, unless a new word loads the same cycle, in which case the flag stays 1 with the new data.
- Timeout (`TIMEOUT_CYCLES`>0):
  - `idle` counts cycles in COLLECT_PARTIAL without `i_byte_valid` and clears on each byte.
  - When `idle` reaches `TIMEOUT_CYCLES`: `cnt` is set to 0, the state returns to COLLECT_EMPTY, `o_timeout` pulses and `asm` contents are don't-care.
  - A byte arriving in the same cycle as the timeout is accepted as byte 0 of a new word, with `ord` re-latched.
- `i_byte_valid` while `cnt`=0 never triggers a timeout. `idle` is held at 0 in COLLECT_EMPTY.
- Reset values: `o_word`=0, `o_word_valid`=0, `o_byte_count`=0, `o_overflow`=0, `o_timeout`=0, `asm`=0, `ord`=0, `idle`=0. Reset mid-word discards the partial word and any unconsumed output word.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency: the N-th `i_byte_valid` at edge t gives `o_word_valid`=1 with the complete word after edge t.
- `o_byte_count` updates the cycle after each byte, wrapping to 0 after byte N.
- Back-to-back `i_byte_valid` on consecutive cycles is supported at full rate.
- The consumer may hold `i_word_ready` high permanently. Throughput is then one word per N bytes, with no loss.
- The timeout pulse occurs `TIMEOUT_CYCLES` edges after the last byte edge, counting only cycles without a byte.
- `o_overflow` and `o_timeout` are each high for exactly 1 cycle per event.

## Test plan
- Byte order, LSB first: N=4, `i_msb_first`=0, bytes 0x11,0x22,0x33,0x44, `i_word_ready`=1 → `o_word`=0x44332211, `o_word_valid` high for 1 cycle, 1 cycle after the last byte.
- Byte order, MSB first: same bytes with `i_msb_first`=1 → `o_word`=0x11223344. Toggling `i_msb_first` after byte 1 does not change the result.
- Backpressure/overflow: `i_word_ready`=0 and 8 bytes 0x01..0x08 → `o_word`=0x04030201 held, `o_overflow` pulses once on byte 8. Then `i_word_ready`=1 → `o_word_valid` drops next cycle.
- Simultaneous accept and load: `o_word_valid`=1 and `i_word_ready`=1 in the cycle byte 4 arrives → `o_word` becomes the new word, `o_word_valid` stays 1, no overflow.
- Timeout: `TIMEOUT_CYCLES`=10, bytes 0xAA,0xBB, then 10 idle cycles → `o_timeout` pulses, `o_byte_count`=0. The next 4 bytes 0x01..0x04 give 0x04030201.
- Reset mid-operation: reset after 2 bytes with an unconsumed word pending → all outputs 0. The next 4 bytes give a correct word.

Source files
------------

// File: rtl/uart_word_assembler.sv
// Packs UART receiver bytes into BYTES_PER_WORD-byte words with selectable byte
// order, an inter-byte timeout and a one-entry valid/ready output register.
module uart_word_assembler #(
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_byte_valid,
    input  logic [BYTE_WIDTH-1:0]                    i_byte,
    input  logic                                     i_msb_first,
    input  logic                                     i_word_ready,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0]     o_word,
    output logic                                     o_word_valid,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]      o_byte_count,
    output logic                                     o_overflow,
    output logic                                     o_timeout
);

    localparam int unsigned WORD_W    = BYTE_WIDTH * BYTES_PER_WORD;
    localparam int unsigned CNT_W     = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam int unsigned IDLE_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic {
        COLLECT_EMPTY   = 1'b0,
        COLLECT_PARTIAL = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_asm;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ord;
    logic [IDLE_W-1:0]   r_idle;
    logic [WORD_W-1:0]   r_word;
    logic                r_word_valid;
    logic                r_overflow;
    logic                r_timeout;

    logic                w_ord;
    logic                w_last_byte;
    logic                w_slot_free;
    logic [WORD_W-1:0]   w_merged;

    // The first byte of a word uses the live order input; later bytes use the latched one.
    assign w_ord       = (r_state == COLLECT_EMPTY) ? i_msb_first : r_ord;
    assign w_last_byte = (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign w_slot_free = !r_word_valid || i_word_ready;

    // Assembly register with the incoming byte merged at its slot.
    always_comb begin
        w_merged = r_asm;
        for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
            if (r_cnt == CNT_W'(k)) begin
                if (w_ord) begin
                    w_merged[(int'(BYTES_PER_WORD) - 1 - k)*int'(BYTE_WIDTH) +: BYTE_WIDTH] = i_byte;
                end else begin
                    w_merged[k*int'(BYTE_WIDTH) +: BYTE_WIDTH] = i_byte;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= COLLECT_EMPTY;
            r_asm        <= '0;
            r_cnt        <= '0;
            r_ord        <= 1'b0;
            r_idle       <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
            if (r_word_valid && i_word_ready) begin
                r_word_valid <= 1'b0;
            end

            if (i_byte_valid) begin
                r_idle <= '0;
                r_asm  <= w_merged;
                if (r_state == COLLECT_EMPTY) begin
                    r_ord <= i_msb_first;
                end
                if (w_last_byte) begin
                    r_cnt   <= '0;
                    r_state <= COLLECT_EMPTY;
                    if (w_slot_free) begin
                        r_word       <= w_merged;
                        r_word_valid <= 1'b1;
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_state <= COLLECT_PARTIAL;
                end
            end else if (TO_EN && r_state == COLLECT_PARTIAL) begin
                // Fires on the idle cycle that completes TIMEOUT_CYCLES idle cycles.
                if (r_idle == IDLE_W'(IDLE_LAST)) begin
                    r_idle    <= '0;
                    r_cnt     <= '0;
                    r_state   <= COLLECT_EMPTY;
                    r_timeout <= 1'b1;
                end else begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_byte_count = r_cnt;
    assign o_overflow   = r_overflow;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Self-checking bench for uart_word_assembler: directed scenarios plus random
// traffic compared against a queue-based word model.
module tb_uart_word_assembler;

    localparam int unsigned BW = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned TO = 10;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_byte_valid;
    logic [BW-1:0]     i_byte;
    logic              i_msb_first;
    logic              i_word_ready;
    logic [BW*N-1:0]   o_word;
    logic              o_word_valid;
    logic [2:0]        o_byte_count;
    logic              o_overflow;
    logic              o_timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  m_q[$];
    bit          m_ord;
    int          m_idle;
    logic [31:0] m_word;
    bit          m_valid;
    bit          m_ovf;
    bit          m_to;

    uart_word_assembler #(
        .BYTE_WIDTH    (BW),
        .BYTES_PER_WORD(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_byte_valid(i_byte_valid),
        .i_byte      (i_byte),
        .i_msb_first (i_msb_first),
        .i_word_ready(i_word_ready),
        .o_word      (o_word),
        .o_word_valid(o_word_valid),
        .o_byte_count(o_byte_count),
        .o_overflow  (o_overflow),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] build_word(input bit ord);
        logic [31:0] w = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (ord) w = w | (32'(m_q[k]) << ((int'(N) - 1 - k) * 8));
            else     w = w | (32'(m_q[k]) << (k * 8));
        end
        return w;
    endfunction

    task automatic model_edge(input bit bv, input logic [7:0] b, input bit msb, input bit rdy);
        bit was_valid = m_valid;
        m_ovf = 1'b0;
        m_to  = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (bv) begin
            if (m_q.size() == 0) m_ord = msb;
            m_q.push_back(b);
            m_idle = 0;
            if (m_q.size() == int'(N)) begin
                if (!was_valid || rdy) begin
                    m_word  = build_word(m_ord);
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
                m_q.delete();
            end
        end else if (m_q.size() > 0) begin
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_q.delete();
                m_idle = 0;
                m_to   = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ":word"},  64'(o_word),       64'(m_word));
        check({tag, ":valid"}, 64'(o_word_valid), 64'(m_valid));
        check({tag, ":count"}, 64'(o_byte_count), 64'(m_q.size()));
        check({tag, ":ovf"},   64'(o_overflow),   64'(m_ovf));
        check({tag, ":tout"},  64'(o_timeout),    64'(m_to));
    endtask

    task automatic step(input string tag, input bit bv, input logic [7:0] b, input bit msb, input bit rdy);
        i_byte_valid = bv;
        i_byte       = b;
        i_msb_first  = msb;
        i_word_ready = rdy;
        @(posedge i_clk);
        model_edge(bv, b, msb, rdy);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        i_reset      = 1'b1;
        i_byte_valid = 1'b0;
        i_byte       = '0;
        i_msb_first  = 1'b0;
        i_word_ready = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        m_q.delete();
        m_ord = 0; m_idle = 0; m_word = '0; m_valid = 0; m_ovf = 0; m_to = 0;
        check("rst:word",  64'(o_word), 64'h0);
        check("rst:valid", 64'(o_word_valid), 64'h0);
        check("rst:count", 64'(o_byte_count), 64'h0);
        check("rst:ovf",   64'(o_overflow), 64'h0);
        check("rst:tout",  64'(o_timeout), 64'h0);
    endtask

    initial begin
        int run;
        bit bv;
        do_reset();

        // LSB-first word
        step("lsb", 1, 8'h11, 0, 1);
        step("lsb", 1, 8'h22, 0, 1);
        step("lsb", 1, 8'h33, 0, 1);
        step("lsb", 1, 8'h44, 0, 1);
        check("lsb_word", 64'(o_word), 64'h44332211);
        check("lsb_valid", 64'(o_word_valid), 64'h1);
        step("lsb_drain", 0, 8'h00, 0, 1);
        check("lsb_valid_drop", 64'(o_word_valid), 64'h0);

        // MSB-first word, order input toggled mid-word
        step("msb", 1, 8'h11, 1, 1);
        step("msb", 1, 8'h22, 0, 1);
        step("msb", 1, 8'h33, 0, 1);
        step("msb", 1, 8'h44, 1, 1);
        check("msb_word", 64'(o_word), 64'h11223344);
        step("msb_drain", 0, 8'h00, 0, 1);

        // Backpressure: second word is dropped
        for (int i = 1; i <= 8; i++) step("bp", 1, 8'(i), 0, 0);
        check("bp_word", 64'(o_word), 64'h04030201);
        check("bp_ovf", 64'(o_overflow), 64'h1);
        step("bp_hold", 0, 8'h00, 0, 0);
        check("bp_ovf_once", 64'(o_overflow), 64'h0);
        step("bp_accept", 0, 8'h00, 0, 1);
        check("bp_valid_drop", 64'(o_word_valid), 64'h0);

        // Accept and load in the same cycle
        for (int i = 1; i <= 4; i++) step("sim", 1, 8'(i), 0, 0);
        for (int i = 5; i <= 7; i++) step("sim", 1, 8'(i), 0, 0);
        step("sim", 1, 8'h08, 0, 1);
        check("sim_word", 64'(o_word), 64'h08070605);
        check("sim_valid", 64'(o_word_valid), 64'h1);
        check("sim_no_ovf", 64'(o_overflow), 64'h0);
        step("sim_drain", 0, 8'h00, 0, 1);

        // Timeout after 10 idle cycles
        step("to", 1, 8'hAA, 0, 1);
        step("to", 1, 8'hBB, 0, 1);
        for (int i = 0; i < int'(TO); i++) step("to_idle", 0, 8'h00, 0, 1);
        check("to_pulse", 64'(o_timeout), 64'h1);
        check("to_count", 64'(o_byte_count), 64'h0);
        for (int i = 1; i <= 4; i++) step("to_next", 1, 8'(i), 0, 1);
        check("to_next_word", 64'(o_word), 64'h04030201);
        step("to_drain", 0, 8'h00, 0, 1);

        // Reset mid-word with a pending output word
        for (int i = 1; i <= 4; i++) step("mr", 1, 8'(8'h50 + i), 0, 0);
        step("mr", 1, 8'hE1, 0, 0);
        step("mr", 1, 8'hE2, 0, 0);
        do_reset();
        for (int i = 1; i <= 4; i++) step("mr_next", 1, 8'(8'hC0 + i), 1, 1);
        check("mr_next_word", 64'(o_word), 64'hC1C2C3C4);

        // Random traffic with occasional long idle gaps
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                run = int'($urandom_range(6, 14));
                for (int j = 0; j < run; j++)
                    step("rnd_gap", 0, 8'($urandom), 1'($urandom), 1'($urandom));
            end
            bv = ($urandom_range(0, 2) != 0);
            step("rnd", bv, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
